// File: rtl/i2c_tx_fifo.sv
// Transmit FIFO between the APB register block and the I2C master byte engine.
// Pointers carry an extra wrap bit so full and empty can be told apart without a separate counter.
// Optional sticky overflow/underflow flags are built only when TX_FIFO_ERR_FLAGS_EN is defined.
module i2c_tx_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AF_LEVEL   = 6
) (
   input  logic                  pclk_i,
   input  logic                  preset_ni,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  rd_en_i,
   input  logic                  flush_i,
   input  logic                  err_clr_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rvalid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic [7:0]            status_o
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rvalid_q;
   logic [ADDR_WIDTH:0]   count;
   logic                  full, empty, almost_full;
   logic                  push_acc, pop_acc;
   logic                  ovf_evt, udf_evt;
   logic                  ovf, udf;

   assign wr_idx      = wr_ptr_q[ADDR_WIDTH-1:0];
   assign rd_idx      = rd_ptr_q[ADDR_WIDTH-1:0];
   assign count       = wr_ptr_q - rd_ptr_q;
   assign empty       = (wr_ptr_q == rd_ptr_q);
   assign full        = (wr_idx == rd_idx) && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
   assign almost_full = (count >= (ADDR_WIDTH + 1)'(AF_LEVEL));

   // Flush overrides both sides; a pop frees a slot so a push on full still fits.
   assign pop_acc  = rd_en_i && !empty && !flush_i;
   assign push_acc = wr_en_i && (!full || pop_acc) && !flush_i;
   assign ovf_evt  = wr_en_i && !flush_i && !push_acc;
   assign udf_evt  = rd_en_i && !flush_i && empty;

   // Next-state pointers
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + (ADDR_WIDTH + 1)'(1);
         if (pop_acc)  rd_ptr_d = rd_ptr_q + (ADDR_WIDTH + 1)'(1);
      end
   end

   // Pointer and read-port registers
   always_ff @(posedge pclk_i) begin
      if (!preset_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rvalid_q <= pop_acc;
         if (pop_acc) rdata_q <= mem_q[rd_idx];
      end
   end

   // Storage array, intentionally not cleared by reset
   always_ff @(posedge pclk_i) begin
      if (preset_ni && push_acc) mem_q[wr_idx] <= wdata_i;
   end

`ifdef TX_FIFO_ERR_FLAGS_EN
   logic ovf_q, udf_q;

   // Sticky error flags; a new event beats a coincident clear
   always_ff @(posedge pclk_i) begin
      if (!preset_ni) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (ovf_evt)        ovf_q <= 1'b1;
         else if (err_clr_i) ovf_q <= 1'b0;
         if (udf_evt)        udf_q <= 1'b1;
         else if (err_clr_i) udf_q <= 1'b0;
      end
   end

   assign ovf = ovf_q;
   assign udf = udf_q;
`else
   logic unused_err;

   assign unused_err = err_clr_i ^ ovf_evt ^ udf_evt;
   assign ovf        = 1'b0;
   assign udf        = 1'b0;
`endif

   assign rdata_o       = rdata_q;
   assign rvalid_o      = rvalid_q;
   assign full_o        = full;
   assign empty_o       = empty;
   assign almost_full_o = almost_full;
   assign count_o       = count;
   assign status_o      = {2'b00, udf, ovf, 1'b0, almost_full, full, empty};

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Directed bench for i2c_tx_fifo; a queue reference model supplies expected data, count and flags.
// Expected error-flag bits follow TX_FIFO_ERR_FLAGS_EN the same way the design does.
module tb_i2c_tx_fifo;

   logic       pclk_i = 1'b0;
   logic       preset_ni;
   logic       wr_en_i, rd_en_i, flush_i, err_clr_i;
   logic [7:0] wdata_i;
   logic [7:0] rdata_o;
   logic       rvalid_o, full_o, empty_o, almost_full_o;
   logic [3:0] count_o;
   logic [7:0] status_o;

   int total = 0;
   int bad   = 0;

   logic [7:0] model[$];
   logic [7:0] last_rd;
   logic       exp_ovf, exp_udf;

   i2c_tx_fifo dut (
      .pclk_i        (pclk_i),
      .preset_ni     (preset_ni),
      .wr_en_i       (wr_en_i),
      .wdata_i       (wdata_i),
      .rd_en_i       (rd_en_i),
      .flush_i       (flush_i),
      .err_clr_i     (err_clr_i),
      .rdata_o       (rdata_o),
      .rvalid_o      (rvalid_o),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .almost_full_o (almost_full_o),
      .count_o       (count_o),
      .status_o      (status_o)
   );

   always #5 pclk_i = ~pclk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk_i);
      #1;
   endtask

   // Compare every state-derived output against the model
   task automatic check_all(input string tag);
      int n;
      logic [7:0] st;
      n  = model.size();
      st = {2'b00, exp_udf, exp_ovf, 1'b0, (n >= 6), (n == 8), (n == 0)};
      check({tag, "_count"}, count_o, n);
      check({tag, "_full"}, full_o, (n == 8));
      check({tag, "_empty"}, empty_o, (n == 0));
      check({tag, "_afull"}, almost_full_o, (n >= 6));
      check({tag, "_status"}, status_o, st);
      check({tag, "_rdata"}, rdata_o, last_rd);
   endtask

   task automatic do_op(input string tag, input logic w, input logic r, input logic [7:0] d,
                        input logic clr);
      logic pop_ok, push_ok;
      pop_ok  = r && (model.size() != 0);
      push_ok = w && ((model.size() < 8) || pop_ok);
      if (pop_ok) last_rd = model.pop_front();
      if (push_ok) model.push_back(d);
`ifdef TX_FIFO_ERR_FLAGS_EN
      if (clr) begin
         exp_ovf = 1'b0;
         exp_udf = 1'b0;
      end
      if (w && !push_ok) exp_ovf = 1'b1;
      if (r && !pop_ok)  exp_udf = 1'b1;
`endif
      wr_en_i = w; rd_en_i = r; wdata_i = d; err_clr_i = clr;
      tick();
      wr_en_i = 1'b0; rd_en_i = 1'b0; err_clr_i = 1'b0;
      check({tag, "_rvalid"}, rvalid_o, pop_ok);
      check_all(tag);
   endtask

   task automatic do_flush(input string tag, input logic w, input logic r);
      flush_i = 1'b1; wr_en_i = w; rd_en_i = r; wdata_i = 8'hEE;
      tick();
      flush_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
      model.delete();
      check({tag, "_rvalid"}, rvalid_o, 1'b0);
      check_all(tag);
   endtask

   task automatic do_reset(input string tag, input logic w);
      preset_ni = 1'b0; wr_en_i = w; wdata_i = 8'hEE;
      tick();
      preset_ni = 1'b1; wr_en_i = 1'b0;
      model.delete();
      last_rd = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0;
      check({tag, "_rvalid"}, rvalid_o, 1'b0);
      check_all(tag);
   endtask

   initial begin
      preset_ni = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; flush_i = 1'b0; err_clr_i = 1'b0;
      wdata_i = 8'h00; last_rd = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0;
      tick();

      // 1: reset then idle
      do_reset("rst", 1'b0);
      do_op("idle", 1'b0, 1'b0, 8'h00, 1'b0);

      // 2: fill A0..A7, drain in order
      for (int i = 0; i < 8; i++) do_op("fillA", 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
      for (int i = 0; i < 8; i++) do_op("popA", 1'b0, 1'b1, 8'h00, 1'b0);

      // 3: overflow on full drops data; sticky flag cleared by err_clr_i
      for (int i = 0; i < 8; i++) do_op("refillA", 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
      do_op("ovf", 1'b1, 1'b0, 8'hFF, 1'b0);
      for (int i = 0; i < 8; i++) do_op("popovf", 1'b0, 1'b1, 8'h00, 1'b0);
      do_op("ovfclr", 1'b0, 1'b0, 8'h00, 1'b1);

      // 4: push+pop on empty: pop rejected, push kept
      do_op("pp_empty", 1'b1, 1'b1, 8'h55, 1'b0);
      do_op("pop55", 1'b0, 1'b1, 8'h00, 1'b0);
      do_op("setwins", 1'b0, 1'b1, 8'h00, 1'b1);
      do_op("udfclr", 1'b0, 1'b0, 8'h00, 1'b1);

      // 5: push+pop on full across the index wrap; 0x11 comes out last
      for (int i = 0; i < 8; i++) do_op("fillB", 1'b1, 1'b0, 8'hB0 + 8'(i), 1'b0);
      do_op("pp_full", 1'b1, 1'b1, 8'h11, 1'b0);
      for (int i = 0; i < 8; i++) do_op("popB", 1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++)
         do_op("mix", (i % 4 != 3), (i % 3 != 0), 8'hC0 + 8'(i), 1'b0);
      for (int i = 0; i < 8; i++) do_op("drain", 1'b0, 1'b1, 8'h00, 1'b0);

      // 6: flush beats a concurrent push/pop; reset mid-burst
      for (int i = 0; i < 5; i++) do_op("fill5", 1'b1, 1'b0, 8'hD0 + 8'(i), 1'b0);
      do_flush("flush_wr", 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) do_op("fill5b", 1'b1, 1'b0, 8'hE0 + 8'(i), 1'b0);
      do_flush("flush_rd", 1'b0, 1'b1);
      do_op("postflush", 1'b1, 1'b0, 8'h77, 1'b0);
      do_op("pop77", 1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) do_op("burst", 1'b1, 1'b0, 8'h90 + 8'(i), 1'b0);
      do_reset("midrst", 1'b1);
      do_op("postrst", 1'b1, 1'b0, 8'h3C, 1'b0);
      do_op("pop3c", 1'b0, 1'b1, 8'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
